// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
//   Shared definitions for the fetch-stage program-counter generator:
//   FSM state encoding, chip-enable / branch / stall encodings, the
//   reset-level constant and the default reset word.
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic BRANCH       = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    // Reset is active-low throughout the fetch stage.
    localparam logic RST_ACTIVE   = 1'b0;

    localparam int unsigned ZERO_WORD = 0;

endpackage

// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
//   Bundle between the PC generator, its redirect sources (control/exception
//   unit, ID branch resolver) and instruction memory.
//   master : the PC generator (drives pc, ce, redirect_pend_o, misalign_o)
//   slave  : the surrounding pipeline / memory (drives stall, branch, flush,
//            new_pc, inst_ack_i)
// -----------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STALL_W = 6
);

    logic [STALL_W-1:0] stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic               inst_ack_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pend_o;
    logic               misalign_o;

    modport master (
        input  stall,
        input  branch_flag_i,
        input  branch_target_address_i,
        input  flush,
        input  new_pc,
        input  inst_ack_i,
        output pc,
        output ce,
        output redirect_pend_o,
        output misalign_o
    );

    modport slave (
        output stall,
        output branch_flag_i,
        output branch_target_address_i,
        output flush,
        output new_pc,
        output inst_ack_i,
        input  pc,
        input  ce,
        input  redirect_pend_o,
        input  misalign_o
    );

endinterface

// File: rtl/pc_redirect_hold.sv
// -----------------------------------------------------------------------------
// pc_redirect_hold
//   Holds a branch redirect that arrived while fetch could not advance.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     set          capture load_target and raise pend (newest overwrites)
//     clr          drop the held redirect
//     load_target  target to capture on set
//     pend         a held redirect is waiting
//     target       the held target address
//   set and clr are never asserted together by pc_gen.
// -----------------------------------------------------------------------------
module pc_redirect_hold
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              clr,
    input  logic [ADDR_W-1:0] load_target,
    output logic              pend,
    output logic [ADDR_W-1:0] target
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            pend <= 1'b0;
        end else if (clr) begin
            pend <= 1'b0;
        end else if (set) begin
            pend <= 1'b1;
        end
    end

    // Target is only meaningful while pend is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (set) begin
            target <= load_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//   Fetch-stage program-counter generator. Produces the fetch address and
//   chip enable toward instruction memory, honours stall and flush, waits on
//   the memory acknowledge and holds a branch redirect that cannot be taken
//   yet so it is applied on the next advance.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   pc_gen_if.master: stall, branch_flag_i, branch_target_address_i,
//           flush, new_pc, inst_ack_i in; pc, ce, redirect_pend_o,
//           misalign_o out
//
//   Configuration macro PC_ALIGN_CHK_EN:
//     defined   : targets load unmodified, misalign_o flags a pc whose low
//                 log2(FETCH_BYTES) bits are non-zero
//     undefined : low log2(FETCH_BYTES) bits of loaded targets are cleared,
//                 misalign_o is tied low
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(ZERO_WORD),
    parameter int unsigned       FETCH_BYTES = 4,
    parameter int unsigned       STALL_W     = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(FETCH_BYTES);
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(FETCH_BYTES - 1);

    function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
`ifdef PC_ALIGN_CHK_EN
        return t;
`else
        return t & ~OFS_MASK;
`endif
    endfunction

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic              adv;
    logic              hold_set, hold_clr, hold_pend;
    logic [ADDR_W-1:0] hold_target;

    assign adv = (state_q == RUN) && (bus.stall[0] == NO_STOP) && bus.inst_ack_i;

    pc_redirect_hold #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .set         (hold_set),
        .clr         (hold_clr),
        .load_target (align_target(bus.branch_target_address_i)),
        .pend        (hold_pend),
        .target      (hold_target)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_set = 1'b0;
        hold_clr = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                state_d = RUN;
                if (bus.flush) begin
                    pc_d     = align_target(bus.new_pc);
                    hold_clr = 1'b1;
                end else if (adv) begin
                    // Any advance consumes the held redirect: either it is
                    // applied now or a newer branch supersedes it.
                    hold_clr = 1'b1;
                    if (bus.branch_flag_i == BRANCH) begin
                        pc_d = align_target(bus.branch_target_address_i);
                    end else if (hold_pend) begin
                        pc_d = hold_target;
                    end else begin
                        pc_d = pc_q + INC;
                    end
                end else if (bus.branch_flag_i == BRANCH) begin
                    hold_set = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef PC_ALIGN_CHK_EN
    assign misalign_d = |(pc_d & OFS_MASK);
`else
    assign misalign_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.ce              = (state_q == RUN) ? CHIP_ENABLE : CHIP_DISABLE;
    assign bus.redirect_pend_o = hold_pend;
    assign bus.misalign_o      = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
//   Two pc_gen instances (FETCH_BYTES=4 and 8) share one stimulus stream.
//   A behavioural model predicts each edge's outcome into a queue tagged
//   with the cycle it applies to; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    logic clk;
    logic rst;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) ifa ();
    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) ifb ();

    pc_gen #(
        .ADDR_W(32), .RESET_PC(32'h0), .FETCH_BYTES(4), .STALL_W(6)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    pc_gen #(
        .ADDR_W(32), .RESET_PC(32'h0), .FETCH_BYTES(8), .STALL_W(6)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural view of the fetch PC.
    // ------------------------------------------------------------------
    typedef struct {
        bit          run;
        logic [31:0] pc;
        bit          pend;
        logic [31:0] tgt;
        bit          mis;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.run = 0; m.pc = 32'h0; m.pend = 0; m.tgt = 32'h0; m.mis = 0;
        return m;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] t, input int fb);
`ifdef PC_ALIGN_CHK_EN
        return t;
`else
        return (t / fb) * fb;
`endif
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input bit rn, input bit st0, input bit br,
                                   input logic [31:0] bt, input bit fl, input logic [31:0] np,
                                   input bit ack, input int fb);
        mdl_t n = s;
        bit go;
        if (!rn) return mdl_reset();
        if (!s.run) begin
            n.run = 1;
            return n;
        end
        go = !st0 && ack;
        if (fl) begin
            n.pc = load_val(np, fb); n.pend = 0;
        end else if (go && br) begin
            n.pc = load_val(bt, fb); n.pend = 0;
        end else if (go && s.pend) begin
            n.pc = s.tgt; n.pend = 0;
        end else if (go) begin
            n.pc = s.pc + 32'(fb);
        end else if (br) begin
            n.pend = 1; n.tgt = load_val(bt, fb);
        end
`ifdef PC_ALIGN_CHK_EN
        n.mis = (n.pc % fb) != 0;
`else
        n.mis = 0;
`endif
        return n;
    endfunction

    typedef struct {
        int          cyc;
        logic [31:0] pca, pcb;
        bit          cea, ceb, pa, pb, ma, mb;
    } exp_t;

    exp_t exp_q[$];
    mdl_t ma, mb;

    task automatic step(input bit rn, input logic [5:0] st, input bit br, input logic [31:0] bt,
                        input bit fl, input logic [31:0] np, input bit ack);
        exp_t e;
        rst = rn;
        ifa.stall = st;  ifb.stall = st;
        ifa.branch_flag_i = br;  ifb.branch_flag_i = br;
        ifa.branch_target_address_i = bt;  ifb.branch_target_address_i = bt;
        ifa.flush = fl;  ifb.flush = fl;
        ifa.new_pc = np;  ifb.new_pc = np;
        ifa.inst_ack_i = ack;  ifb.inst_ack_i = ack;
        ma = mstep(ma, rn, st[0], br, bt, fl, np, ack, 4);
        mb = mstep(mb, rn, st[0], br, bt, fl, np, ack, 8);
        e.cyc = cyc + 1;
        e.pca = ma.pc;  e.pcb = mb.pc;
        e.cea = ma.run; e.ceb = mb.run;
        e.pa = ma.pend; e.pb = mb.pend;
        e.ma = ma.mis;  e.mb = mb.mis;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every edge for which a prediction exists.
    // ------------------------------------------------------------------
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                chk("sb_a_pc",   ifa.pc,              mon_e.pca);
                chk("sb_a_ce",   32'(ifa.ce),         32'(mon_e.cea));
                chk("sb_a_pend", 32'(ifa.redirect_pend_o), 32'(mon_e.pa));
                chk("sb_a_mis",  32'(ifa.misalign_o), 32'(mon_e.ma));
                chk("sb_b_pc",   ifb.pc,              mon_e.pcb);
                chk("sb_b_ce",   32'(ifb.ce),         32'(mon_e.ceb));
                chk("sb_b_pend", 32'(ifb.redirect_pend_o), 32'(mon_e.pb));
                chk("sb_b_mis",  32'(ifb.misalign_o), 32'(mon_e.mb));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [5:0] rs;
        ma = mdl_reset();
        mb = mdl_reset();
        rst = 1'b0;
        ifa.stall = '0; ifb.stall = '0;
        ifa.branch_flag_i = 0; ifb.branch_flag_i = 0;
        ifa.branch_target_address_i = '0; ifb.branch_target_address_i = '0;
        ifa.flush = 0; ifb.flush = 0;
        ifa.new_pc = '0; ifb.new_pc = '0;
        ifa.inst_ack_i = 0; ifb.inst_ack_i = 0;
        #1;
        chk("rst_pc", ifa.pc, 32'h0);
        chk("rst_ce", 32'(ifa.ce), 32'h0);
        chk("rst_pend", 32'(ifa.redirect_pend_o), 32'h0);
        chk("rst_mis", 32'(ifa.misalign_o), 32'h0);

        step(0, 6'h00, 0, 0, 0, 0, 1);
        step(0, 6'h00, 0, 0, 0, 0, 1);
        chk("rst_hold_ce", 32'(ifa.ce), 32'h0);

        // Release: first edge only enables fetch
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("boot_ce", 32'(ifa.ce), 32'h1);
        chk("boot_pc", ifa.pc, 32'h0);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("seq_pc4", ifa.pc, 32'h4);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("seq_pc8", ifa.pc, 32'h8);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("seq_pc12", ifa.pc, 32'hC);
        chk("seq_b_pc24", ifb.pc, 32'h18);

        // Branch during stall is held, then applied
        step(1, 6'h00, 0, 0, 1, 32'h20, 1);
        chk("flush_pc20", ifa.pc, 32'h20);
        step(1, 6'h3F, 1, 32'h100, 0, 0, 1);
        chk("stall_br_pc", ifa.pc, 32'h20);
        chk("stall_br_pend", 32'(ifa.redirect_pend_o), 32'h1);
        step(1, 6'h3F, 0, 0, 0, 0, 1);
        chk("stall_hold_pc", ifa.pc, 32'h20);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("release_pc", ifa.pc, 32'h100);
        chk("release_pend", 32'(ifa.redirect_pend_o), 32'h0);

        // Flush while stalled, ack low, with a redirect pending
        step(1, 6'h01, 1, 32'h140, 0, 0, 0);
        chk("pend_set2", 32'(ifa.redirect_pend_o), 32'h1);
        step(1, 6'h01, 0, 0, 1, 32'h180, 0);
        chk("flush_stall_pc", ifa.pc, 32'h180);
        chk("flush_stall_pend", 32'(ifa.redirect_pend_o), 32'h0);

        // Flush and branch together: branch dropped
        step(1, 6'h01, 1, 32'h200, 1, 32'h180, 0);
        chk("fl_br_pc", ifa.pc, 32'h180);
        chk("fl_br_pend", 32'(ifa.redirect_pend_o), 32'h0);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("fl_br_after", ifa.pc, 32'h184);

        // Wrap at the top of the address space
        step(1, 6'h00, 0, 0, 1, 32'hFFFF_FFF8, 1);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("wrap_b_pc", ifb.pc, 32'h0);
        chk("wrap_a_pc", ifa.pc, 32'hFFFF_FFFC);

        // Misaligned branch target
        step(1, 6'h00, 1, 32'h102, 0, 0, 1);
`ifdef PC_ALIGN_CHK_EN
        chk("misal_pc", ifa.pc, 32'h102);
        chk("misal_flag", 32'(ifa.misalign_o), 32'h1);
`else
        chk("misal_pc", ifa.pc, 32'h100);
        chk("misal_flag", 32'(ifa.misalign_o), 32'h0);
`endif
        step(1, 6'h00, 0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rs = 6'($urandom);
            rs[0] = ($urandom_range(0, 3) == 0);
            step(1, rs, ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 15) == 0),
                 $urandom, ($urandom_range(0, 4) != 0));
        end

        // Asynchronous reset with a redirect pending
        step(1, 6'h01, 1, 32'h300, 0, 0, 1);
        chk("pre_rst_pend", 32'(ifa.redirect_pend_o), 32'h1);
        #4;
        rst = 1'b0;
        exp_q.delete();
        ma = mdl_reset();
        mb = mdl_reset();
        #1;
        chk("arst_pc", ifa.pc, 32'h0);
        chk("arst_ce", 32'(ifa.ce), 32'h0);
        chk("arst_pend", 32'(ifa.redirect_pend_o), 32'h0);
        chk("arst_b_pend", 32'(ifb.redirect_pend_o), 32'h0);
        chk("arst_mis", 32'(ifa.misalign_o), 32'h0);
        @(posedge clk);
        #1;
        step(0, 6'h00, 0, 0, 0, 0, 1);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        step(1, 6'h00, 0, 0, 0, 0, 1);
        chk("post_rst_pc", ifa.pc, 32'h4);

        for (int i = 0; i < 200; i++) begin
            rs = 6'($urandom);
            rs[0] = ($urandom_range(0, 2) == 0);
            step(1, rs, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 20) == 0),
                 $urandom, ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        #5;
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
